// File: rtl/cheri_data_mem_responder_if.sv
// Data-side bus between the core (master) and a tagged-word memory responder
// (slave): req/gnt acceptance, then in-order rvalid replies.
interface cheri_data_mem_responder_if #(
   parameter int unsigned DataWidth = 33
);
   logic                 data_req_i;
   logic                 data_is_cap_i;
   logic                 data_we_i;
   logic [3:0]           data_be_i;
   logic [31:0]          data_addr_i;
   logic [DataWidth-1:0] data_wdata_i;
   logic                 gnt_stall_i;
   logic                 data_gnt_o;
   logic                 data_rvalid_o;
   logic [DataWidth-1:0] data_rdata_o;
   logic                 data_err_o;

   modport master (
      output data_req_i, data_is_cap_i, data_we_i, data_be_i,
      output data_addr_i, data_wdata_i, gnt_stall_i,
      input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
   );

   modport slave (
      input  data_req_i, data_is_cap_i, data_we_i, data_be_i,
      input  data_addr_i, data_wdata_i, gnt_stall_i,
      output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
   );
endinterface

// File: rtl/cheri_data_mem_responder.sv
// Tagged-word data memory on the core's req/gnt/rvalid port: CHERIoT tag
// rules on write/read, in-order replies after a fixed latency.
module cheri_data_mem_responder #(
   parameter int unsigned DataWidth   = 33,
   parameter logic [31:0] MemBase     = 32'h8000_0000,
   parameter int unsigned MemDepthW   = 10,
   parameter int unsigned RespLatency = 1
) (
   input logic                       clk_i,
   input logic                       rst_ni,
   cheri_data_mem_responder_if.slave bus
);
   localparam int unsigned Words = 1 << MemDepthW;
   localparam logic [32:0] MemLo = {1'b0, MemBase};
   localparam logic [32:0] MemHi = MemLo + (33'd1 << (MemDepthW + 2));

   logic                 accept;
   logic                 in_range;
   logic                 cap_bad;
   logic                 acc_err;
   logic                 mem_we;
   logic [32:0]          addr_ext;
   logic [MemDepthW-1:0] idx;
   logic [DataWidth-1:0] rd_word;
   logic [DataWidth-1:0] wr_word;
   logic [DataWidth-1:0] rsp_data;

   logic [DataWidth-1:0] mem_q [Words];

   logic                 st_v_d;
   logic                 st_e_d;
   logic [DataWidth-1:0] st_r_d;
   logic                 st_v_q [RespLatency];
   logic                 st_e_q [RespLatency];
   logic [DataWidth-1:0] st_r_q [RespLatency];

   assign accept          = bus.data_req_i & ~bus.gnt_stall_i;
   assign bus.data_gnt_o  = accept;

   // Range is checked on the full address so out-of-range never aliases.
   assign addr_ext = {1'b0, bus.data_addr_i};
   assign in_range = (addr_ext >= MemLo) && (addr_ext < MemHi);
   assign cap_bad  = bus.data_is_cap_i &
                     ((bus.data_addr_i[1:0] != 2'b00) |
                      (bus.data_be_i != 4'hF));
   assign acc_err  = ~in_range | cap_bad;
   assign idx      = MemDepthW'((bus.data_addr_i - MemBase) >> 2);
   assign rd_word  = mem_q[idx];
   assign mem_we   = accept & bus.data_we_i & ~acc_err;

   // Non-cap stores merge enabled bytes and always strip the tag.
   always_comb begin
      wr_word = '0;
      if (bus.data_is_cap_i) begin
         wr_word = bus.data_wdata_i;
      end else begin
         wr_word[31:0] = rd_word[31:0];
         for (int b = 0; b < 4; b++) begin
            if (bus.data_be_i[b]) begin
               wr_word[8*b +: 8] = bus.data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rsp_data = '0;
      if (!acc_err && !bus.data_we_i) begin
         rsp_data = {bus.data_is_cap_i & rd_word[32], rd_word[31:0]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[idx] <= wr_word;
      end
   end

   always_comb begin
      st_v_d = accept;
      st_e_d = accept & acc_err;
      st_r_d = accept ? rsp_data : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < RespLatency; i++) begin
            st_v_q[i] <= 1'b0;
            st_e_q[i] <= 1'b0;
            st_r_q[i] <= '0;
         end
      end else begin
         st_v_q[0] <= st_v_d;
         st_e_q[0] <= st_e_d;
         st_r_q[0] <= st_r_d;
         for (int i = 1; i < RespLatency; i++) begin
            st_v_q[i] <= st_v_q[i-1];
            st_e_q[i] <= st_e_q[i-1];
            st_r_q[i] <= st_r_q[i-1];
         end
      end
   end

   assign bus.data_rvalid_o = st_v_q[RespLatency-1];
   assign bus.data_err_o    = st_e_q[RespLatency-1];
   assign bus.data_rdata_o  = st_r_q[RespLatency-1];
endmodule

// File: tb/tb_cheri_data_mem_responder.sv
// Directed bench: three responders (latency 1, 3, 4) share one stimulus
// stream; expected replies are queued at drive time and matched on rvalid.
module tb_cheri_data_mem_responder;
   localparam logic [31:0] B = 32'h8000_0000;

   typedef struct {
      int          due;
      logic        err;
      logic [32:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_req = 1'b0;
   logic        s_cap = 1'b0;
   logic        s_we = 1'b0;
   logic [3:0]  s_be = 4'h0;
   logic [31:0] s_addr = 32'h0;
   logic [32:0] s_wd = 33'h0;
   logic        s_stall = 1'b0;

   logic [2:0]  gnt_w;
   logic [2:0]  rv_w;
   logic [2:0]  err_w;
   logic [32:0] rd_w [3];

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q [3][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      cheri_data_mem_responder_if #(.DataWidth(33)) bus ();
      assign bus.data_req_i    = s_req;
      assign bus.data_is_cap_i = s_cap;
      assign bus.data_we_i     = s_we;
      assign bus.data_be_i     = s_be;
      assign bus.data_addr_i   = s_addr;
      assign bus.data_wdata_i  = s_wd;
      assign bus.gnt_stall_i   = s_stall;
      assign gnt_w[g]          = bus.data_gnt_o;
      assign rv_w[g]           = bus.data_rvalid_o;
      assign err_w[g]          = bus.data_err_o;
      assign rd_w[g]           = bus.data_rdata_o;

      cheri_data_mem_responder #(
         .DataWidth  (33),
         .MemBase    (B),
         .MemDepthW  (10),
         .RespLatency((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
         .clk_i (clk),
         .rst_ni(rst_n),
         .bus   (bus)
      );
   end

   function automatic int lat(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
   endfunction

   task automatic chk(input string tag, input int k,
                      input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h",
                tag, k, cyc, obs, exp);
      end
   endtask

   // Per-cycle scoreboard: rvalid must match the head's due cycle exactly.
   task automatic mon(input int k);
      exp_t f;
      logic ev;
      while (q[k].size() > 0 && q[k][0].due < cyc) void'(q[k].pop_front());
      ev = (q[k].size() > 0) && (q[k][0].due == cyc);
      chk("rvalid", k, {32'h0, rv_w[k]}, {32'h0, ev});
      if (ev) begin
         f = q[k].pop_front();
         chk("rdata", k, rd_w[k], f.rdata);
         chk("err", k, {32'h0, err_w[k]}, {32'h0, f.err});
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 3; k++) mon(k);
      end
   end

   task automatic acc(input logic cap, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [32:0] wd,
                      input logic ee, input logic [32:0] er);
      exp_t e;
      @(negedge clk);
      s_req = 1'b1; s_stall = 1'b0;
      s_cap = cap; s_we = we; s_be = be; s_addr = addr; s_wd = wd;
      for (int k = 0; k < 3; k++) begin
         e.due = cyc + lat(k);
         e.err = ee;
         e.rdata = er;
         q[k].push_back(e);
      end
      #1;
      for (int k = 0; k < 3; k++) chk("gnt", k, {32'h0, gnt_w[k]}, 33'h1);
   endtask

   task automatic stall_cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         s_req = 1'b1; s_stall = 1'b1;
         #1;
         for (int k = 0; k < 3; k++) chk("gnt_stall", k, {32'h0, gnt_w[k]}, 33'h0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         s_req = 1'b0; s_stall = 1'b0;
      end
   endtask

   task automatic chk_zero(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk({tag, "_rv"}, k, {32'h0, rv_w[k]}, 33'h0);
         chk({tag, "_err"}, k, {32'h0, err_w[k]}, 33'h0);
         chk({tag, "_rdata"}, k, rd_w[k], 33'h0);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1 chk_zero("reset");
      rst_n = 1'b1;

      // Cap write/read round trip and tag clear by narrow store.
      acc(1, 1, 4'hF, B, 33'h1_DEAD_BEEF, 0, 33'h0);
      acc(1, 0, 4'hF, B, 33'h0, 0, 33'h1_DEAD_BEEF);
      acc(0, 1, 4'h1, B, 33'h0_0000_0011, 0, 33'h0);
      acc(1, 0, 4'hF, B, 33'h0, 0, 33'h0_DEAD_BE11);
      acc(0, 0, 4'hF, B, 33'h0, 0, 33'h0_DEAD_BE11);
      acc(1, 1, 4'hF, B + 20, 33'h1_1234_5678, 0, 33'h0);
      acc(0, 0, 4'hF, B + 20, 33'h0, 0, 33'h0_1234_5678);
      acc(0, 0, 4'h0, B + 20, 33'h0, 0, 33'h0_1234_5678);
      acc(1, 0, 4'hF, B + 20, 33'h0, 0, 33'h1_1234_5678);
      acc(1, 1, 4'hF, B + 24, 33'h1_AAAA_5555, 0, 33'h0);
      acc(0, 1, 4'h0, B + 24, 33'h1_FFFF_FFFF, 0, 33'h0);
      acc(1, 0, 4'hF, B + 24, 33'h0, 0, 33'h0_AAAA_5555);
      idle(2);

      // Errors, followed by reads proving nothing was written.
      acc(0, 1, 4'hF, B + 4092, 33'h0_1357_9BDF, 0, 33'h0);
      acc(1, 0, 4'hF, B + 2, 33'h0, 1, 33'h0);
      acc(1, 1, 4'h3, B, 33'h1_FFFF_FFFF, 1, 33'h0);
      acc(1, 1, 4'hF, B + 1, 33'h1_FFFF_FFFF, 1, 33'h0);
      acc(0, 0, 4'hF, B + 4096, 33'h0, 1, 33'h0);
      acc(0, 1, 4'hF, B + 4096, 33'h0_CAFE_F00D, 1, 33'h0);
      acc(0, 1, 4'hF, 32'h7FFF_FFFC, 33'h0_CAFE_F00D, 1, 33'h0);
      acc(0, 0, 4'hF, 32'h7FFF_FFFC, 33'h0, 1, 33'h0);
      acc(0, 0, 4'hF, 32'hFFFF_FFFC, 33'h0, 1, 33'h0);
      acc(1, 0, 4'hF, B, 33'h0, 0, 33'h0_DEAD_BE11);
      acc(0, 0, 4'hF, B + 4092, 33'h0, 0, 33'h0_1357_9BDF);
      acc(0, 0, 4'hF, B + 2, 33'h0, 0, 33'h0_DEAD_BE11);
      idle(3);

      // Streaming reads, then a two-cycle stall mid-stream.
      for (int i = 0; i < 4; i++) acc(0, 1, 4'hF, B + 4*i, 33'(i + 1), 0, 33'h0);
      for (int i = 0; i < 4; i++) acc(1, 0, 4'hF, B + 4*i, 33'h0, 0, 33'(i + 1));
      acc(0, 0, 4'hF, B, 33'h0, 0, 33'h1);
      acc(0, 0, 4'hF, B + 4, 33'h0, 0, 33'h2);
      stall_cyc(2);
      acc(0, 0, 4'hF, B + 8, 33'h0, 0, 33'h3);
      acc(0, 0, 4'hF, B + 12, 33'h0, 0, 33'h4);
      idle(6);

      // Reset while reads are in flight; stored words must survive.
      acc(0, 0, 4'hF, B + 8, 33'h0, 0, 33'h3);
      acc(0, 0, 4'hF, B + 12, 33'h0, 0, 33'h4);
      @(negedge clk);
      s_req = 1'b0;
      #2 rst_n = 1'b0;
      for (int k = 0; k < 3; k++) q[k].delete();
      #1 chk_zero("midrst");
      @(negedge clk);
      chk_zero("midrst_hold");
      rst_n = 1'b1;
      idle(6);
      acc(0, 0, 4'hF, B + 12, 33'h0, 0, 33'h4);
      acc(1, 0, 4'hF, B + 20, 33'h0, 0, 33'h1_1234_5678);
      idle(6);

      for (int k = 0; k < 3; k++) chk("drained", k, 33'(q[k].size()), 33'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
